// File: rtl/jamma_joy_reader.sv
// Serial reader for the JAMMA/DB9 joystick shift-register chain.
// Generates chain clock/load, demuxes 24 bits into two debounced active-low player words.
module jamma_joy_reader #(
    parameter int CLK_DIV         = 16,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    input  logic        JOY_DATA,
    output logic [11:0] O_JOY1,
    output logic [11:0] O_JOY2,
    output logic        O_FRAME_DONE,
    output logic        O_UPDATED
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MC_W  = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [MC_W-1:0]  MC_LAST   = MC_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [4:0]       LAST_SLOT = 5'd25;

    typedef struct packed {
        logic       valid;
        logic       p2;
        logic [3:0] idx;
    } slot_dst_t;

    // Slots 2..17 carry bits 8,6..0 of J1 then J2; slots 18..25 carry 10,11,9,7 of J2 then J1.
    function automatic slot_dst_t slot_map(input logic [4:0] s);
        slot_dst_t  d;
        logic [2:0] pos;
        d   = '0;
        pos = '0;
        if (s >= 5'd2 && s <= 5'd17) begin
            d.valid = 1'b1;
            d.p2    = (s >= 5'd10);
            pos     = d.p2 ? 3'(s - 5'd10) : 3'(s - 5'd2);
            d.idx   = (pos == 3'd0) ? 4'd8 : {1'b0, 3'd7 - pos};
        end else if (s >= 5'd18 && s <= 5'd25) begin
            d.valid = 1'b1;
            d.p2    = (s <= 5'd21);
            case (s[1:0])
                2'd2:    d.idx = 4'd10;
                2'd3:    d.idx = 4'd11;
                2'd0:    d.idx = 4'd9;
                default: d.idx = 4'd7;
            endcase
        end
        return d;
    endfunction

    logic             data_meta, data_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       slot, slot_nxt;
    logic [11:0]      shadow1, shadow2, sh1_nxt, sh2_nxt;
    logic [11:0]      prev1, prev2;
    logic [MC_W-1:0]  match_cnt, match_nxt;
    logic             primed, rise, frame_end, same, commit;
    slot_dst_t        dst;

    assign rise      = (div_cnt == DIV_LAST) && !JOY_CLK;
    assign frame_end = rise && (slot == LAST_SLOT);
    assign slot_nxt  = (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
    assign dst       = slot_map(slot);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        sh1_nxt = shadow1;
        sh2_nxt = shadow2;
        if (rise && dst.valid) begin
            if (dst.p2) sh2_nxt[dst.idx] = data_sync;
            else        sh1_nxt[dst.idx] = data_sync;
        end
    end

    assign same      = ({sh1_nxt, sh2_nxt} == {prev1, prev2});
    assign match_nxt = !same ? '0 : (match_cnt == MC_LAST) ? match_cnt : match_cnt + 1'b1;
    assign commit    = (match_nxt == MC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            div_cnt   <= '0;
            JOY_CLK   <= 1'b0;
            JOY_LOAD  <= 1'b1;
            slot      <= LAST_SLOT;
            shadow1   <= 12'hFFF;
            shadow2   <= 12'hFFF;
        end else begin
            data_meta <= JOY_DATA;
            data_sync <= data_meta;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                JOY_CLK <= !JOY_CLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (rise) begin
                slot     <= slot_nxt;
                JOY_LOAD <= (slot_nxt != 5'd0);
                shadow1  <= sh1_nxt;
                shadow2  <= sh2_nxt;
            end
        end
    end

    // The first frame end after reset closes a partial frame and is only used to arm the reader.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            primed       <= 1'b0;
            match_cnt    <= '0;
            prev1        <= 12'hFFF;
            prev2        <= 12'hFFF;
            O_JOY1       <= 12'hFFF;
            O_JOY2       <= 12'hFFF;
            O_FRAME_DONE <= 1'b0;
            O_UPDATED    <= 1'b0;
        end else begin
            O_FRAME_DONE <= 1'b0;
            O_UPDATED    <= 1'b0;
            if (frame_end) begin
                if (!primed) begin
                    primed <= 1'b1;
                end else begin
                    O_FRAME_DONE <= 1'b1;
                    match_cnt    <= match_nxt;
                    prev1        <= sh1_nxt;
                    prev2        <= sh2_nxt;
                    if (commit) begin
                        O_JOY1    <= sh1_nxt;
                        O_JOY2    <= sh2_nxt;
                        O_UPDATED <= ({sh1_nxt, sh2_nxt} != {O_JOY1, O_JOY2});
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jamma_joy_reader.sv
// Directed bench for jamma_joy_reader: a chain model feeds three instances
// (CLK_DIV/DEBOUNCE 16/2, 16/1, 1/2) and each scenario task checks its own results.
module tb_jamma_joy_reader;

    logic I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    logic        I_RESET;
    logic        joy16, joy1;
    logic [2:0]  jclk, jload, fd, upd;
    logic [11:0] j1 [3];
    logic [11:0] j2 [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ecnt   = 0;
    int done_cnt [3];
    int upd_cnt  [3];
    int done_cyc [3];
    logic [25:0] raw_tab [32];

    localparam logic [11:0] WALK_J1 [24] = '{
        12'hEFF, 12'hFBF, 12'hFDF, 12'hFEF, 12'hFF7, 12'hFFB, 12'hFFD, 12'hFFE,
        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hBFF, 12'h7FF, 12'hDFF, 12'hF7F};
    localparam logic [11:0] WALK_J2 [24] = '{
        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
        12'hEFF, 12'hFBF, 12'hFDF, 12'hFEF, 12'hFF7, 12'hFFB, 12'hFFD, 12'hFFE,
        12'hBFF, 12'h7FF, 12'hDFF, 12'hF7F, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

    jamma_joy_reader #(.CLK_DIV(16), .DEBOUNCE_FRAMES(2)) u_a (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .JOY_CLK(jclk[0]), .JOY_LOAD(jload[0]),
        .JOY_DATA(joy16), .O_JOY1(j1[0]), .O_JOY2(j2[0]),
        .O_FRAME_DONE(fd[0]), .O_UPDATED(upd[0]));
    jamma_joy_reader #(.CLK_DIV(16), .DEBOUNCE_FRAMES(1)) u_b (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .JOY_CLK(jclk[1]), .JOY_LOAD(jload[1]),
        .JOY_DATA(joy16), .O_JOY1(j1[1]), .O_JOY2(j2[1]),
        .O_FRAME_DONE(fd[1]), .O_UPDATED(upd[1]));
    jamma_joy_reader #(.CLK_DIV(1), .DEBOUNCE_FRAMES(2)) u_c (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .JOY_CLK(jclk[2]), .JOY_LOAD(jload[2]),
        .JOY_DATA(joy1), .O_JOY1(j1[2]), .O_JOY2(j2[2]),
        .O_FRAME_DONE(fd[2]), .O_UPDATED(upd[2]));

    // Rise r occurs at edge (2r+1)*cd after release; rise 0 reads slot 25, rise r>=1 reads
    // slot (r-1)%26 of frame (r-1)/26.
    function automatic logic raw_bit(input int r);
        int f, s;
        if (r == 0) return raw_tab[0][25];
        f = (r - 1) / 26;
        s = (r - 1) % 26;
        if (f > 31) f = 31;
        return raw_tab[f][s];
    endfunction

    // Data is correct only for the single edge that feeds the two-flop resampler for a rise;
    // every other edge sees the complement, so an off-edge sample lands a wrong bit.
    function automatic logic data_for(input int cd, input int tgt);
        int per, r;
        per = 2 * cd;
        if (tgt % per == cd) return raw_bit(tgt / per);
        r = (tgt <= cd) ? 0 : (tgt - cd + per - 1) / per;
        return ~raw_bit(r);
    endfunction

    initial begin
        joy16 = 1'b1;
        joy1  = 1'b1;
        forever begin
            @(posedge I_CLK);
            cyc  = cyc + 1;
            ecnt = I_RESET ? 0 : ecnt + 1;
            #1;
            if (I_RESET) begin
                joy16 = 1'b1;
                joy1  = 1'b1;
            end else begin
                joy16 = data_for(16, ecnt + 3);
                joy1  = data_for(1, ecnt + 3);
            end
        end
    end

    initial begin
        forever begin
            @(negedge I_CLK);
            for (int i = 0; i < 3; i++) begin
                if (fd[i]) begin
                    done_cnt[i] = done_cnt[i] + 1;
                    done_cyc[i] = cyc;
                end
                if (upd[i]) upd_cnt[i] = upd_cnt[i] + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic fill_all(input logic [25:0] v);
        for (int f = 0; f < 32; f++) raw_tab[f] = v;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            done_cnt[i] = 0;
            upd_cnt[i]  = 0;
            done_cyc[i] = 0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge I_CLK);
        I_RESET = 1'b1;
        repeat (n) @(negedge I_CLK);
        clear_counts();
        I_RESET = 1'b0;
    endtask

    task automatic wait_done(input int which, input int n);
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt[which] >= n) return;
            @(negedge I_CLK);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_done inst %0d: saw %0d frames, required %0d", which, done_cnt[which], n);
    endtask

    task automatic test_reset();
        int first_rise, first_low, low_cnt, first_done;
        fill_all('1);
        @(negedge I_CLK);
        I_RESET = 1'b1;
        repeat (10) @(negedge I_CLK);
        #1;
        checks++; if (jclk[0] !== 1'b0) begin errors++; $display("FAIL reset_joy_clk got %b exp 0", jclk[0]); end
        checks++; if (jload[0] !== 1'b1) begin errors++; $display("FAIL reset_joy_load got %b exp 1", jload[0]); end
        checks++; if (j1[0] !== 12'hFFF) begin errors++; $display("FAIL reset_joy1 got %h exp fff", j1[0]); end
        checks++; if (j2[0] !== 12'hFFF) begin errors++; $display("FAIL reset_joy2 got %h exp fff", j2[0]); end
        checks++; if (fd[0] !== 1'b0 || upd[0] !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", fd[0], upd[0]); end
        @(negedge I_CLK);
        clear_counts();
        I_RESET = 1'b0;
        first_rise = -1; first_low = -1; low_cnt = 0; first_done = -1;
        for (int k = 1; k <= 900; k++) begin
            @(negedge I_CLK);
            #1;
            if (jclk[0] && first_rise < 0) first_rise = k;
            if (!jload[0] && k < 848) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end
            if (fd[0]) begin
                first_done = k;
                break;
            end
        end
        checks++; if (first_rise != 16) begin errors++; $display("FAIL first_rise got %0d exp 16", first_rise); end
        checks++; if (first_low != 16) begin errors++; $display("FAIL load_start got %0d exp 16", first_low); end
        checks++; if (low_cnt != 32) begin errors++; $display("FAIL load_width got %0d exp 32", low_cnt); end
        checks++; if (first_done != 848) begin errors++; $display("FAIL first_valid_frame got %0d exp 848", first_done); end
        checks++; if (j1[0] !== 12'hFFF || j2[0] !== 12'hFFF) begin errors++; $display("FAIL idle_words got %h/%h exp fff/fff", j1[0], j2[0]); end
        checks++; if (upd_cnt[0] != 0) begin errors++; $display("FAIL idle_updated got %0d exp 0", upd_cnt[0]); end
    endtask

    task automatic test_main();
        logic [25:0] v;
        int t1;
        v = '1; v[6] = 1'b0; v[20] = 1'b0;
        fill_all(v);
        do_reset(3);
        wait_done(0, 1);
        t1 = done_cyc[0];
        checks++; if (j1[0] !== 12'hFFF || j2[0] !== 12'hFFF) begin errors++; $display("FAIL main_frame1 got %h/%h exp fff/fff", j1[0], j2[0]); end
        wait_done(0, 2);
        checks++; if (j1[0] !== 12'hFF7) begin errors++; $display("FAIL main_joy1 got %h exp ff7", j1[0]); end
        checks++; if (j2[0] !== 12'hDFF) begin errors++; $display("FAIL main_joy2 got %h exp dff", j2[0]); end
        checks++; if (upd_cnt[0] != 1) begin errors++; $display("FAIL main_updated got %0d exp 1", upd_cnt[0]); end
        checks++; if (done_cyc[0] - t1 != 832) begin errors++; $display("FAIL frame_spacing got %0d exp 832", done_cyc[0] - t1); end
        wait_done(0, 3);
        checks++; if (j1[0] !== 12'hFF7 || j2[0] !== 12'hDFF || upd_cnt[0] != 1) begin
            errors++; $display("FAIL main_hold got %h/%h upd %0d exp ff7/dff upd 1", j1[0], j2[0], upd_cnt[0]);
        end
    endtask

    task automatic test_walk();
        logic [25:0] v;
        for (int f = 0; f < 32; f++) begin
            v = '1;
            if (f < 24) v[f + 2] = 1'b0;
            raw_tab[f] = v;
        end
        do_reset(3);
        for (int f = 0; f < 24; f++) begin
            wait_done(1, f + 1);
            checks++; if (j1[1] !== WALK_J1[f] || j2[1] !== WALK_J2[f]) begin
                errors++; $display("FAIL walk_slot%0d got %h/%h exp %h/%h", f + 2, j1[1], j2[1], WALK_J1[f], WALK_J2[f]);
            end
        end
        checks++; if (upd_cnt[1] != 24) begin errors++; $display("FAIL walk_updated got %0d exp 24", upd_cnt[1]); end
    endtask

    task automatic test_glitch();
        logic [11:0] exp_b [5];
        logic [25:0] v;
        exp_b = '{12'hFFF, 12'hFFF, 12'hFEF, 12'hFFF, 12'hFFF};
        fill_all('1);
        v = '1; v[5] = 1'b0;
        raw_tab[2] = v;
        do_reset(3);
        for (int f = 0; f < 5; f++) begin
            wait_done(1, f + 1);
            checks++; if (j1[1] !== exp_b[f]) begin errors++; $display("FAIL glitch_db1_f%0d got %h exp %h", f, j1[1], exp_b[f]); end
            checks++; if (j1[0] !== 12'hFFF) begin errors++; $display("FAIL glitch_db2_f%0d got %h exp fff", f, j1[0]); end
        end
        checks++; if (upd_cnt[0] != 0) begin errors++; $display("FAIL glitch_db2_updated got %0d exp 0", upd_cnt[0]); end
        checks++; if (upd_cnt[1] != 2) begin errors++; $display("FAIL glitch_db1_updated got %0d exp 2", upd_cnt[1]); end
    endtask

    task automatic test_reset_midframe();
        logic [25:0] v;
        logic prevc;
        int rises, rel;
        v = '1; v[6] = 1'b0; v[20] = 1'b0;
        fill_all(v);
        do_reset(3);
        wait_done(0, 2);
        checks++; if (j1[0] !== 12'hFF7 || j2[0] !== 12'hDFF) begin errors++; $display("FAIL mid_pressed got %h/%h exp ff7/dff", j1[0], j2[0]); end
        prevc = jclk[0];
        rises = 0;
        for (int k = 0; k < 2000 && rises < 12; k++) begin
            @(negedge I_CLK);
            #1;
            if (jclk[0] && !prevc) rises++;
            prevc = jclk[0];
        end
        #2;
        I_RESET = 1'b1;
        #1;
        checks++; if (j1[0] !== 12'hFFF || j2[0] !== 12'hFFF) begin errors++; $display("FAIL mid_async_words got %h/%h exp fff/fff", j1[0], j2[0]); end
        checks++; if (jload[0] !== 1'b1 || jclk[0] !== 1'b0) begin errors++; $display("FAIL mid_async_chain got clk %b load %b exp 0 1", jclk[0], jload[0]); end
        repeat (3) @(negedge I_CLK);
        clear_counts();
        rel = cyc;
        I_RESET = 1'b0;
        wait_done(0, 1);
        checks++; if (done_cyc[0] - rel != 848) begin errors++; $display("FAIL mid_discard got %0d exp 848", done_cyc[0] - rel); end
        checks++; if (j1[0] !== 12'hFFF || j2[0] !== 12'hFFF) begin errors++; $display("FAIL mid_frame1 got %h/%h exp fff/fff", j1[0], j2[0]); end
        wait_done(0, 2);
        checks++; if (j1[0] !== 12'hFF7 || j2[0] !== 12'hDFF || upd_cnt[0] != 1) begin
            errors++; $display("FAIL mid_restore got %h/%h upd %0d exp ff7/dff upd 1", j1[0], j2[0], upd_cnt[0]);
        end
    endtask

    task automatic test_clk_div1();
        logic [25:0] v;
        int t1;
        v = '1; v[9] = 1'b0; v[10] = 1'b0;
        fill_all(v);
        do_reset(3);
        for (int k = 1; k <= 4; k++) begin
            @(negedge I_CLK);
            #1;
            checks++; if (jclk[2] !== logic'(k % 2)) begin errors++; $display("FAIL div1_toggle_%0d got %b exp %0d", k, jclk[2], k % 2); end
        end
        wait_done(2, 1);
        t1 = done_cyc[2];
        checks++; if (j1[2] !== 12'hFFF) begin errors++; $display("FAIL div1_frame1 got %h exp fff", j1[2]); end
        wait_done(2, 2);
        checks++; if (done_cyc[2] - t1 != 52) begin errors++; $display("FAIL div1_spacing got %0d exp 52", done_cyc[2] - t1); end
        checks++; if (j1[2] !== 12'hFFE) begin errors++; $display("FAIL div1_joy1 got %h exp ffe", j1[2]); end
        checks++; if (j2[2] !== 12'hEFF) begin errors++; $display("FAIL div1_joy2 got %h exp eff", j2[2]); end
        checks++; if (upd_cnt[2] != 1) begin errors++; $display("FAIL div1_updated got %0d exp 1", upd_cnt[2]); end
    endtask

    initial begin
        I_RESET = 1'b1;
        clear_counts();
        test_reset();
        test_main();
        test_glitch();
        test_walk();
        test_reset_midframe();
        test_clk_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
